// File: rtl/multicycle_control_pkg.sv
// Shared types for the multi-cycle RV32I control FSM.
// MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN adds the TRAP state.
package multicycle_control_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
    , TRAP
`endif
  } state_t;

  typedef enum logic [2:0] {
    NOP,
    R,
    IALU,
    LOAD,
    STORE,
    BRANCH,
    ILLEGAL
  } class_t;

endpackage

// File: rtl/multicycle_control_opcode_class_decoder.sv
// Combinational opcode -> instruction class lookup.
// Anything outside the five supported classes is ILLEGAL.
module opcode_class_decoder
  import multicycle_control_pkg::*;
(
  input  logic [6:0] opcode,
  output class_t     cls
);

  always_comb begin
    cls = ILLEGAL;
    unique case (1'b1)
      (opcode == OP_R):      cls = R;
      (opcode == OP_IALU):   cls = IALU;
      (opcode == OP_LOAD):   cls = LOAD;
      (opcode == OP_STORE):  cls = STORE;
      (opcode == OP_BRANCH): cls = BRANCH;
      default:               cls = ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control with memory timeout.
// MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN: illegal opcodes trap.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [6:0]       opcode,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic             branch,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             timeout_err,
  output logic             trap,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state;
  state_t     state_nx;
  class_t     cls;
  class_t     cls_dec;
  logic [7:0] to_cnt;
  logic       retire;
  logic       waiting;
  logic       ready;
  logic       to_hit;

  opcode_class_decoder u_dec (
    .opcode (opcode),
    .cls    (cls_dec)
  );

  assign waiting = (state == FETCH) || (state == MEM);
  assign ready   = (state == FETCH) ? imem_ready : dmem_ready;
  // Ready on the last allowed cycle still wins.
  assign to_hit  = waiting && !ready && (to_cnt == TO_LAST);

`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
  assign trap = (state == TRAP);
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    state_nx   = state;
    retire     = 1'b0;
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    unique case (state)
      IDLE: begin
        if (en) state_nx = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_nx = DECODE;
        end else if (to_hit) begin
          state_nx = IDLE;
        end
      end
      DECODE: begin
        if (cls_dec != ILLEGAL) state_nx = EXEC;
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
        else state_nx = TRAP;
`else
        else state_nx = FETCH;
`endif
      end
      EXEC: begin
        unique case (cls)
          R: begin
            alu_op   = ALU_FUNCT;
            state_nx = WB;
          end
          IALU: begin
            alu_src  = 1'b1;
            alu_op   = ALU_FUNCT;
            state_nx = WB;
          end
          LOAD, STORE: begin
            alu_src  = 1'b1;
            state_nx = MEM;
          end
          BRANCH: begin
            alu_op   = ALU_SUB;
            branch   = 1'b1;
            retire   = 1'b1;
            state_nx = en ? FETCH : IDLE;
          end
          default: state_nx = FETCH;
        endcase
      end
      MEM: begin
        alu_src   = 1'b1;
        mem_read  = (cls == LOAD);
        mem_write = (cls == STORE);
        if (dmem_ready) begin
          if (cls == LOAD) begin
            state_nx = WB;
          end else begin
            retire   = 1'b1;
            state_nx = en ? FETCH : IDLE;
          end
        end else if (to_hit) begin
          state_nx = IDLE;
        end
      end
      WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls == LOAD);
        retire     = 1'b1;
        state_nx   = en ? FETCH : IDLE;
      end
      default: state_nx = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cls         <= NOP;
      to_cnt      <= '0;
      timeout_err <= 1'b0;
      retire_cnt  <= '0;
    end else begin
      state <= state_nx;
      if (state == DECODE)
        cls <= (cls_dec == ILLEGAL) ? NOP : cls_dec;
      // Leaving a wait state always passes through zero.
      if (waiting && !ready) to_cnt <= to_cnt + 8'd1;
      else                   to_cnt <= '0;
      if (to_hit) timeout_err <= 1'b1;
      if (retire) retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control (MEM_TIMEOUT=4, CNT_W=4).
// Works with or without MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       imem_ready = 1'b0;
  logic       dmem_ready = 1'b0;
  logic       imem_req, ir_write, pc_write, branch, alu_src;
  logic [1:0] alu_op;
  logic       mem_read, mem_write, reg_write, mem_to_reg;
  logic       timeout_err, trap;
  logic [3:0] retire_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  multicycle_control #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .opcode(opcode),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write),
    .branch(branch), .alu_src(alu_src), .alu_op(alu_op),
    .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .timeout_err(timeout_err), .trap(trap), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] T_R  = 7'b0110011;
  localparam logic [6:0] T_I  = 7'b0010011;
  localparam logic [6:0] T_LD = 7'b0000011;
  localparam logic [6:0] T_ST = 7'b0100011;
  localparam logic [6:0] T_BR = 7'b1100011;

  typedef struct packed {
    logic [6:0] op;
    int         iw;
    int         dw;
    int         lat;
    int         rw;
    int         m2r;
    int         mr;
    int         mw;
    int         br;
    logic [1:0] aop;
    logic       asrc;
    logic       to;
    int         ret;
  } vec_t;

  vec_t vt [10];
  vec_t sb [$];

  function automatic logic [11:0] outs();
    return {imem_req, ir_write, pc_write, branch, alu_src, alu_op,
            mem_read, mem_write, reg_write, mem_to_reg, trap};
  endfunction

  task automatic chk(input string what, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", what, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    vec_t       e;
    int         cyc, icnt, dcnt;
    int         rw, m2r, mr, mw, br, irw, pcw;
    logic [1:0] aop;
    logic       asrc;
    logic [3:0] rc0;
    logic       to0;
    bit         done;
    string      tag;
    sb.push_back(v);
    tag = $sformatf("v%0d", idx);
    cyc = 0; icnt = 0; dcnt = 0;
    rw = 0; m2r = 0; mr = 0; mw = 0; br = 0; irw = 0; pcw = 0;
    aop = 2'b11; asrc = 1'bx; done = 0;
    rc0 = retire_cnt; to0 = timeout_err;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    while (!done && cyc < 40) begin
      imem_ready = imem_req && (icnt == v.iw);
      if (imem_req) icnt++;
      dmem_ready = (mem_read || mem_write) && (dcnt == v.dw);
      if (mem_read || mem_write) dcnt++;
      if (imem_ready) opcode = v.op;
      #1;
      if (retire_cnt != rc0 || timeout_err != to0) begin
        done = 1;
      end else begin
        rw  += int'(reg_write);
        m2r += int'(mem_to_reg);
        mr  += int'(mem_read);
        mw  += int'(mem_write);
        br  += int'(branch);
        irw += int'(ir_write);
        pcw += int'(pc_write);
        if (cyc == v.iw + 2) begin
          aop  = alu_op;
          asrc = alu_src;
        end
        cyc++;
        @(negedge clk);
      end
    end
    e = sb.pop_front();
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " latency"}, 32'(cyc), 32'(e.lat));
    chk({tag, " reg_write cycles"}, 32'(rw), 32'(e.rw));
    chk({tag, " mem_to_reg cycles"}, 32'(m2r), 32'(e.m2r));
    chk({tag, " mem_read cycles"}, 32'(mr), 32'(e.mr));
    chk({tag, " mem_write cycles"}, 32'(mw), 32'(e.mw));
    chk({tag, " branch cycles"}, 32'(br), 32'(e.br));
    chk({tag, " ir_write cycles"}, 32'(irw), 32'd1);
    chk({tag, " pc_write cycles"}, 32'(pcw), 32'd1);
    chk({tag, " exec alu_op"}, 32'(aop), 32'(e.aop));
    chk({tag, " exec alu_src"}, 32'(asrc), 32'(e.asrc));
    chk({tag, " retire delta"}, 32'(4'(retire_cnt - rc0)), 32'(e.ret));
    chk({tag, " timeout_err"}, 32'(timeout_err), 32'(e.to));
    chk({tag, " idle outputs"}, 32'(outs()), 32'd0);
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
  endtask

  initial begin
    //      op    iw dw lat rw m2r mr mw br aop  src  to  ret
    vt[0] = '{T_R,  0, 0, 4,  1, 0,  0, 0, 0, 2'd2, 1'b0, 1'b0, 1};
    vt[1] = '{T_R,  1, 0, 5,  1, 0,  0, 0, 0, 2'd2, 1'b0, 1'b0, 1};
    vt[2] = '{T_I,  0, 0, 4,  1, 0,  0, 0, 0, 2'd2, 1'b1, 1'b0, 1};
    vt[3] = '{T_LD, 0, 3, 8,  1, 1,  4, 0, 0, 2'd0, 1'b1, 1'b0, 1};
    vt[4] = '{T_LD, 2, 0, 7,  1, 1,  1, 0, 0, 2'd0, 1'b1, 1'b0, 1};
    vt[5] = '{T_ST, 0, 2, 6,  0, 0,  0, 3, 0, 2'd0, 1'b1, 1'b0, 1};
    vt[6] = '{T_BR, 0, 0, 3,  0, 0,  0, 0, 1, 2'd1, 1'b0, 1'b0, 1};
    vt[7] = '{T_BR, 3, 0, 6,  0, 0,  0, 0, 1, 2'd1, 1'b0, 1'b0, 1};
    vt[8] = '{T_ST, 0, 0, 4,  0, 0,  0, 1, 0, 2'd0, 1'b1, 1'b0, 1};
    vt[9] = '{T_LD, 0, 99, 7, 0, 0,  4, 0, 0, 2'd0, 1'b1, 1'b1, 0};

    do_reset();
    #1;
    chk("reset outputs", 32'(outs()), 32'd0);
    chk("reset retire_cnt", 32'(retire_cnt), 32'd0);
    chk("reset timeout_err", 32'(timeout_err), 32'd0);

    for (int i = 0; i < 10; i++) run_vec(vt[i], i);

    repeat (3) @(negedge clk);
    #1;
    chk("sticky timeout_err", 32'(timeout_err), 32'd1);
    chk("post-timeout idle", 32'(outs()), 32'd0);
    chk("post-timeout retire_cnt", 32'(retire_cnt), 32'd9);

    // Illegal opcode
    do_reset();
    en = 1'b1; opcode = 7'b1111111;
    @(negedge clk);
    en = 1'b0; imem_ready = 1'b1;
    #1 chk("illegal fetch ir_write", 32'(ir_write), 32'd1);
    @(negedge clk);
    imem_ready = 1'b0;
    #1 chk("illegal decode outputs", 32'(outs()), 32'd0);
    @(negedge clk);
    #1;
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
    chk("trap set", 32'(trap), 32'd1);
    chk("trap imem_req", 32'(imem_req), 32'd0);
    repeat (4) @(negedge clk);
    #1 chk("trap held", 32'(outs()), 32'd1);
    chk("trap retire_cnt", 32'(retire_cnt), 32'd0);
    do_reset();
    #1 chk("trap cleared", 32'(trap), 32'd0);
`else
    chk("illegal refetch", 32'(imem_req), 32'd1);
    chk("illegal trap", 32'(trap), 32'd0);
    chk("illegal retire_cnt", 32'(retire_cnt), 32'd0);
`endif

    // Reset while in MEM
    do_reset();
    en = 1'b1; opcode = T_ST;
    @(negedge clk);
    en = 1'b0; imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 chk("mem_write in MEM", 32'(mem_write), 32'd1);
    @(negedge clk);
    #1 chk("mem_write held", 32'(mem_write), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    #1 chk("reset in MEM outputs", 32'(outs()), 32'd0);
    chk("reset in MEM retire", 32'(retire_cnt), 32'd0);
    chk("reset in MEM timeout", 32'(timeout_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1 chk("idle after reset", 32'(outs()), 32'd0);

    // Back-to-back R and counter wrap
    do_reset();
    en = 1'b1; imem_ready = 1'b1; opcode = T_R;
    repeat (65) @(posedge clk);
    #1 chk("retire_cnt 16 wraps", 32'(retire_cnt), 32'd0);
    repeat (4) @(posedge clk);
    #1 chk("retire_cnt 17", 32'(retire_cnt), 32'd1);
    en = 1'b0;
    repeat (6) @(negedge clk);
    #1 chk("drain retire_cnt", 32'(retire_cnt), 32'd2);
    chk("drain idle", 32'(outs()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
